// File: rtl/isa_tx_scheduler_if.sv
// Requester handshake plus ring write port of the outbound TX scheduler.
// master = scheduler side; slave = requesters, ring RAM and consumer pointer side.
interface isa_tx_scheduler_if #(
  parameter int NREQ = 4,
  parameter int AW   = 13
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] tag;
  logic [8*NREQ-1:0] data;
  logic [NREQ-1:0]   ack;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [7:0]        wr_data;

  modport master (
    input  req, tag, data, rd_ptr,
    output ack, wr_en, wr_addr, wr_data
  );

  modport slave (
    output req, tag, data, rd_ptr,
    input  ack, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/isa_tx_scheduler.sv
// Round-robin writer of ISA capture events (tag byte, data byte) into the outbound ring; ISA_TX_STATS_EN adds peak level.
// Latency: req sampled in IDLE at N -> tag written N+1, data + ack N+2, next arbitration N+4.
// Backpressure: no grant while fewer than 2 free slots; requests wait, chrdy_hold stalls the ISA bus.
module isa_tx_scheduler #(
  parameter int NREQ     = 4,
  parameter int AW       = 13,
  parameter int HI_WM    = 2000,
  parameter int STALL_WM = 8000
) (
  input  logic               clk,
  input  logic               rst_n,
  isa_tx_scheduler_if.master bus,
  input  logic               i_stats_clr,
  output logic [AW-1:0]      o_level,
  output logic               o_hi_wm,
  output logic               o_chrdy_hold,
  output logic [AW-1:0]      o_peak_level
);
  localparam int            GW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] HI_WM_L    = AW'(HI_WM);
  localparam logic [AW-1:0] STALL_WM_L = AW'(STALL_WM);
  localparam logic [AW-1:0] ONE        = AW'(1);
  localparam logic [AW-1:0] TWO        = AW'(2);
  localparam logic [GW-1:0] LAST_RST   = GW'(NREQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_TAG, S_DATA, S_GAP} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_wp;
  logic [GW-1:0]   r_last;
  logic [GW-1:0]   r_gnt;
  logic [7:0]      r_data_g;
  logic [NREQ-1:0] r_ack;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [7:0]      r_wr_data;
  logic [AW-1:0]   r_level;
  logic            r_hi_wm;
  logic            r_chrdy_hold;

  logic [AW-1:0]   w_level;
  logic [AW-1:0]   w_free;
  logic            w_room;
  logic            w_gnt_vld;
  logic [GW-1:0]   w_gnt;
  logic [7:0]      w_tag_sel;
  logic [7:0]      w_data_sel;

  // One slot is always kept empty so that wp == rd_ptr unambiguously means empty.
  assign w_level = r_wp - bus.rd_ptr;
  assign w_free  = {AW{1'b1}} - w_level;
  assign w_room  = (w_free >= TWO);

  // Scan last+NREQ down to last+1 so the nearest requester after last wins.
  always_comb begin
    logic [GW-1:0] v_idx;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    v_idx     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      v_idx = GW'((int'(r_last) + k) % NREQ);
      if (bus.req[v_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = v_idx;
      end
    end
  end

  always_comb begin
    w_tag_sel  = '0;
    w_data_sel = '0;
    for (int c = 0; c < NREQ; c++) begin
      if (w_gnt == GW'(c)) begin
        w_tag_sel  = bus.tag[8*c +: 8];
        w_data_sel = bus.data[8*c +: 8];
      end
    end
  end

  // Write strobes are prepared one state ahead so they leave the block registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wp      <= '0;
      r_last    <= LAST_RST;
      r_gnt     <= '0;
      r_data_g  <= '0;
      r_ack     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_ack   <= '0;
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld && w_room) begin
            r_gnt     <= w_gnt;
            r_data_g  <= w_data_sel;
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_wp;
            r_wr_data <= w_tag_sel;
            r_state   <= S_TAG;
          end
        end
        S_TAG: begin
          r_wp         <= r_wp + ONE;
          r_wr_en      <= 1'b1;
          r_wr_addr    <= r_wp + ONE;
          r_wr_data    <= r_data_g;
          r_ack[r_gnt] <= 1'b1;
          r_state      <= S_DATA;
        end
        S_DATA: begin
          r_wp    <= r_wp + ONE;
          r_last  <= r_gnt;
          r_state <= S_GAP;
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level      <= '0;
      r_hi_wm      <= 1'b0;
      r_chrdy_hold <= 1'b0;
    end else begin
      r_level      <= w_level;
      r_hi_wm      <= (w_level >= HI_WM_L);
      r_chrdy_hold <= (w_level >= STALL_WM_L);
    end
  end

`ifdef ISA_TX_STATS_EN
  logic [AW-1:0] r_peak_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak_level <= '0;
    end else if (i_stats_clr) begin
      r_peak_level <= r_level;
    end else if (r_level > r_peak_level) begin
      r_peak_level <= r_level;
    end
  end

  assign o_peak_level = r_peak_level;
`else
  logic w_unused_stats_clr;
  assign w_unused_stats_clr = i_stats_clr;
  assign o_peak_level       = '0;
`endif

  assign bus.ack      = r_ack;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign o_level      = r_level;
  assign o_hi_wm      = r_hi_wm;
  assign o_chrdy_hold = r_chrdy_hold;
endmodule

// File: tb/tb_isa_tx_scheduler.sv
// Testbench for isa_tx_scheduler: directed scenarios plus randomized traffic against a ring/arbiter model.
`timescale 1ns/1ps
module tb_isa_tx_scheduler;
  localparam int NREQ     = 4;
  localparam int AW       = 13;
  localparam int DEPTH    = 1 << AW;
  localparam int HI_WM    = 2000;
  localparam int STALL_WM = 8000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stats_clr = 1'b0;
  logic [AW-1:0] level;
  logic [AW-1:0] peak_level;
  logic          hi_wm;
  logic          chrdy_hold;
  int            checks = 0;
  int            errors = 0;
  int            grant_log[$];

  isa_tx_scheduler_if #(.NREQ(NREQ), .AW(AW)) bus ();

  isa_tx_scheduler #(.NREQ(NREQ), .AW(AW), .HI_WM(HI_WM), .STALL_WM(STALL_WM)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .i_stats_clr  (stats_clr),
    .o_level      (level),
    .o_hi_wm      (hi_wm),
    .o_chrdy_hold (chrdy_hold),
    .o_peak_level (peak_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    bus.req    = '0;
    bus.tag    = '0;
    bus.data   = '0;
    bus.rd_ptr = '0;
    stats_clr  = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.req    = 4'b1111;
    bus.tag    = 32'hA5A5_A5A5;
    bus.data   = 32'h5A5A_5A5A;
    bus.rd_ptr = 13'd7;
    repeat (3) tick();
    checks++; if (bus.ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b want 0000", bus.ack); end
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
    checks++; if (bus.wr_addr !== 13'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", bus.wr_addr); end
    checks++; if (bus.wr_data !== 8'd0) begin errors++; $display("FAIL reset_wr_data: got %h want 00", bus.wr_data); end
    checks++; if (level !== 13'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (hi_wm !== 1'b0 || chrdy_hold !== 1'b0) begin errors++; $display("FAIL reset_wm: got hi=%b hold=%b want 0 0", hi_wm, chrdy_hold); end
    checks++; if (peak_level !== 13'd0) begin errors++; $display("FAIL reset_peak: got %0d want 0", peak_level); end
    bus.req    = '0;
    bus.rd_ptr = '0;
    rst_n      = 1'b1;
    tick();
    checks++; if (bus.wr_en !== 1'b0 || level !== 13'd0) begin errors++; $display("FAIL reset_release: got wr_en=%b level=%0d want 0 0", bus.wr_en, level); end
  endtask

  task automatic test_single();
    int lat;
    do_reset();
    bus.tag[23:16]  = 8'h88;
    bus.data[23:16] = 8'h21;
    bus.req         = 4'b0100;
    lat = 0;
    do begin tick(); lat++; end while (bus.wr_en !== 1'b1 && lat < 20);
    checks++; if (lat != 1) begin errors++; $display("FAIL single_latency: got %0d cycles want 1", lat); end
    checks++; if (bus.wr_addr !== 13'd0 || bus.wr_data !== 8'h88 || bus.ack !== 4'b0) begin
      errors++; $display("FAIL single_tag: got addr=%0d data=%h ack=%b want 0 88 0000", bus.wr_addr, bus.wr_data, bus.ack);
    end
    tick();
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 13'd1 || bus.wr_data !== 8'h21 || bus.ack !== 4'b0100) begin
      errors++; $display("FAIL single_data: got en=%b addr=%0d data=%h ack=%b want 1 1 21 0100", bus.wr_en, bus.wr_addr, bus.wr_data, bus.ack);
    end
    bus.req = '0;
    tick();
    checks++; if (bus.ack !== 4'b0 || bus.wr_en !== 1'b0) begin errors++; $display("FAIL single_gap: got ack=%b en=%b want 0000 0", bus.ack, bus.wr_en); end
    repeat (3) tick();
    checks++; if (level !== 13'd2 || bus.wr_en !== 1'b0) begin errors++; $display("FAIL single_level: got level=%0d en=%b want 2 0", level, bus.wr_en); end
  endtask

  // Drives NREQ requesters and checks every cycle against a ring model:
  // rotating-priority grant from the requests the scheduler saw, consecutive
  // tag/data bytes at the model write pointer, ack pulse, level and watermarks.
  task automatic run_traffic(input int ncyc, input bit sat, input bit move_rd);
    logic [NREQ-1:0] req_d, prev_req;
    logic [7:0]      ptag [NREQ];
    logic [7:0]      pdat [NREQ];
    int              dly  [NREQ];
    int m_wp, m_last, m_g, phase, prev_wp, prev_rd, rd, wp_start, exp_lvl, g, last_tag, n_events, avail;
    req_d = '0; prev_req = '0;
    for (int c = 0; c < NREQ; c++) begin ptag[c] = '0; pdat[c] = '0; dly[c] = 0; end
    m_wp = 0; m_last = NREQ - 1; m_g = 0; phase = 0; prev_wp = 0; prev_rd = 0; rd = 0;
    last_tag = -1; n_events = 0;
    grant_log.delete();
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      tick();
      wp_start = m_wp;
      exp_lvl  = (prev_wp - prev_rd + DEPTH) % DEPTH;
      checks++; if (level !== AW'(exp_lvl)) begin errors++; $display("FAIL traffic_level: cyc %0d got %0d want %0d", cyc, level, exp_lvl); end
      checks++; if (hi_wm !== (exp_lvl >= HI_WM) || chrdy_hold !== (exp_lvl >= STALL_WM)) begin
        errors++; $display("FAIL traffic_wm: cyc %0d got hi=%b hold=%b for level %0d", cyc, hi_wm, chrdy_hold, exp_lvl);
      end
      if (phase == 1) begin
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== AW'(m_wp) || bus.wr_data !== pdat[m_g] || bus.ack !== NREQ'(1 << m_g)) begin
          errors++; $display("FAIL traffic_data: cyc %0d got en=%b addr=%0d data=%h ack=%b want 1 %0d %h ch%0d",
                             cyc, bus.wr_en, bus.wr_addr, bus.wr_data, bus.ack, m_wp, pdat[m_g], m_g);
        end
        m_wp = (m_wp + 1) % DEPTH; m_last = m_g; phase = 0; n_events++;
        req_d[m_g] = 1'b0;
        dly[m_g]   = sat ? 1 : int'($urandom_range(1, 4));
      end else if (bus.wr_en === 1'b1) begin
        g = -1;
        for (int k = 1; k <= NREQ; k++) if (g < 0 && prev_req[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
        if (g < 0) begin
          checks++; errors++; $display("FAIL traffic_grant: cyc %0d got write addr=%0d with no request pending", cyc, bus.wr_addr);
          g = 0;
        end
        checks++;
        if (bus.wr_addr !== AW'(m_wp) || bus.wr_data !== ptag[g] || bus.ack !== 4'b0) begin
          errors++; $display("FAIL traffic_tag: cyc %0d got addr=%0d data=%h ack=%b want %0d %h (ch%0d) 0000",
                             cyc, bus.wr_addr, bus.wr_data, bus.ack, m_wp, ptag[g], g);
        end
        if (sat && last_tag >= 0) begin
          checks++; if (cyc - last_tag != 4) begin errors++; $display("FAIL traffic_rate: got %0d cycles between events want 4", cyc - last_tag); end
        end
        last_tag = cyc;
        grant_log.push_back(g);
        m_g = g; phase = 1; m_wp = (m_wp + 1) % DEPTH;
      end else begin
        checks++; if (bus.ack !== 4'b0) begin errors++; $display("FAIL traffic_ack: cyc %0d got stray ack=%b want 0000", cyc, bus.ack); end
      end
      for (int c = 0; c < NREQ; c++) begin
        if (!req_d[c]) begin
          if (dly[c] > 0) dly[c]--;
          else if (sat || $urandom_range(0, 3) == 0) begin
            req_d[c] = 1'b1;
            ptag[c]  = 8'($urandom);
            pdat[c]  = 8'($urandom);
          end
        end
        bus.tag[8*c +: 8]  = ptag[c];
        bus.data[8*c +: 8] = pdat[c];
      end
      bus.req = req_d;
      if (move_rd && $urandom_range(0, 2) == 0) begin
        avail = (m_wp - rd + DEPTH) % DEPTH;
        rd    = (rd + int'($urandom_range(0, avail))) % DEPTH;
      end
      bus.rd_ptr = AW'(rd);
      prev_req   = req_d;
      prev_wp    = wp_start;
      prev_rd    = rd;
    end
    checks++; if (n_events < ncyc / 16) begin errors++; $display("FAIL traffic_progress: got %0d events want >= %0d", n_events, ncyc / 16); end
    bus.req = '0;
  endtask

  task automatic test_fairness();
    do_reset();
    run_traffic(64, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (i >= grant_log.size()) begin
        errors++; $display("FAIL fair_order: grant %0d missing, got %0d grants", i, grant_log.size());
      end else if (grant_log[i] != i % NREQ) begin
        errors++; $display("FAIL fair_order: grant %0d got ch%0d want ch%0d", i, grant_log[i], i % NREQ);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    run_traffic(1500, 1'b0, 1'b1);
  endtask

  task automatic test_full_wrap();
    int cyc, seen;
    do_reset();
    bus.tag[7:0]  = 8'h5A;
    bus.data[7:0] = 8'hC3;
    bus.req       = 4'b0001;
    cyc = 0;
    while (level !== 13'd8190 && cyc < 20000) begin tick(); cyc++; end
    checks++; if (level !== 13'd8190) begin errors++; $display("FAIL full_fill: got level %0d want 8190", level); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (bus.wr_en === 1'b1) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL full_nogrant: got %0d writes want 0", seen); end
    checks++; if (level !== 13'd8190 || chrdy_hold !== 1'b1 || hi_wm !== 1'b1) begin
      errors++; $display("FAIL full_hold: got level=%0d hold=%b hi=%b want 8190 1 1", level, chrdy_hold, hi_wm);
    end
    bus.rd_ptr = 13'd2;
    cyc = 0;
    do begin tick(); cyc++; end while (bus.wr_en !== 1'b1 && cyc < 10);
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 13'd8190 || bus.wr_data !== 8'h5A) begin
      errors++; $display("FAIL wrap_tag: got en=%b addr=%0d data=%h want 1 8190 5a", bus.wr_en, bus.wr_addr, bus.wr_data);
    end
    tick();
    checks++; if (bus.wr_addr !== 13'd8191 || bus.wr_data !== 8'hC3 || bus.ack !== 4'b0001) begin
      errors++; $display("FAIL wrap_data: got addr=%0d data=%h ack=%b want 8191 c3 0001", bus.wr_addr, bus.wr_data, bus.ack);
    end
    bus.req = '0;
    repeat (3) tick();
    checks++; if (level !== 13'd8190) begin errors++; $display("FAIL wrap_level: got %0d want 8190", level); end
    bus.rd_ptr = 13'd0;
    repeat (2) tick();
    checks++; if (level !== 13'd0 || chrdy_hold !== 1'b0 || hi_wm !== 1'b0) begin
      errors++; $display("FAIL wrap_empty: got level=%0d hold=%b hi=%b want 0 0 0", level, chrdy_hold, hi_wm);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, acks;
    do_reset();
    bus.tag[15:8]  = 8'h11;
    bus.data[15:8] = 8'h22;
    bus.req        = 4'b0010;
    cyc = 0;
    do begin tick(); cyc++; end while (bus.ack !== 4'b0010 && cyc < 10);
    bus.req = '0;
    repeat (3) tick();
    bus.tag[15:8]  = 8'h3C;
    bus.data[15:8] = 8'h77;
    bus.req        = 4'b0010;
    cyc = 0;
    do begin tick(); cyc++; end while (bus.wr_en !== 1'b1 && cyc < 10);
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 13'd2) begin errors++; $display("FAIL mid_tag: got en=%b addr=%0d want 1 2", bus.wr_en, bus.wr_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== 13'd0 || bus.wr_data !== 8'd0 || bus.ack !== 4'b0 || level !== 13'd0) begin
      errors++; $display("FAIL mid_reset_outputs: got en=%b addr=%0d data=%h ack=%b level=%0d want all 0", bus.wr_en, bus.wr_addr, bus.wr_data, bus.ack, level);
    end
    acks = 0;
    repeat (5) begin tick(); if (bus.ack !== 4'b0 || bus.wr_en !== 1'b0) acks++; end
    checks++; if (acks != 0) begin errors++; $display("FAIL mid_no_ack: got %0d active cycles in reset want 0", acks); end
    bus.req = '0;
    rst_n   = 1'b1;
    tick();
    bus.req = 4'b0010;
    cyc = 0;
    do begin tick(); cyc++; end while (bus.wr_en !== 1'b1 && cyc < 10);
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 13'd0 || bus.wr_data !== 8'h3C) begin
      errors++; $display("FAIL mid_restart: got en=%b addr=%0d data=%h want 1 0 3c", bus.wr_en, bus.wr_addr, bus.wr_data);
    end
    bus.req = '0;
  endtask

  task automatic test_stats();
    int cyc;
    do_reset();
    bus.tag[31:24]  = 8'hE1;
    bus.data[31:24] = 8'h9F;
    bus.req         = 4'b1000;
    cyc = 0;
    while (level !== 13'd40 && cyc < 400) begin tick(); cyc++; end
    bus.req = '0;
    repeat (3) tick();
    checks++; if (level !== 13'd40) begin errors++; $display("FAIL stats_fill: got level %0d want 40", level); end
    bus.rd_ptr = 13'd30;
    repeat (4) tick();
    checks++; if (level !== 13'd10) begin errors++; $display("FAIL stats_drain: got level %0d want 10", level); end
`ifdef ISA_TX_STATS_EN
    checks++; if (peak_level !== 13'd40) begin errors++; $display("FAIL stats_peak: got %0d want 40", peak_level); end
`else
    checks++; if (peak_level !== 13'd0) begin errors++; $display("FAIL stats_peak_off: got %0d want 0", peak_level); end
`endif
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    tick();
`ifdef ISA_TX_STATS_EN
    checks++; if (peak_level !== 13'd10) begin errors++; $display("FAIL stats_clr: got %0d want 10", peak_level); end
`else
    checks++; if (peak_level !== 13'd0) begin errors++; $display("FAIL stats_clr_off: got %0d want 0", peak_level); end
`endif
  endtask

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_random();
    test_full_wrap();
    test_reset_mid();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
